// File: rtl/i2c_target_byte_mac_pkg.sv
// i2c_target_pkg: FSM encoding, ACK/NACK levels and bit-counter helpers for the I2C byte target.
package i2c_target_pkg;
   localparam int CNT_W = 4;
   localparam logic ACK = 1'b0;
   localparam logic NACK = 1'b1;
   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_RX_BYTE, S_RX_ACK, S_TX_LOAD, S_TX_BYTE, S_TX_ACK
   } state_t;
   function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
      return &c ? c : c + 1'b1;
   endfunction
endpackage

// File: rtl/i2c_target_byte_mac_input_sync.sv
// i2c_input_sync: multi-flop synchronizer with rise/fall detect on the two oldest stages.
module i2c_input_sync #(
   parameter int STAGES = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);
   logic [STAGES-1:0] sync_q, sync_d;
   always_comb sync_d = {sync_q[STAGES-2:0], d_i};
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= '1;
      else sync_q <= sync_d;
   end
   assign q_o    = sync_q[STAGES-2];
   assign rise_o = sync_q[STAGES-2] & ~sync_q[STAGES-1];
   assign fall_o = ~sync_q[STAGES-2] & sync_q[STAGES-1];
endmodule

// File: rtl/i2c_target_byte_mac.sv
// i2c_target_byte_mac: I2C target byte engine with address match, RX/TX byte handshakes and clock stretching.
module i2c_target_byte_mac
   import i2c_target_pkg::*;
#(
   parameter logic [6:0] I2C_ADDR     = 7'h42,
   parameter int         SYNC_STAGES  = 3,
   parameter bit         STRETCH_EN   = 1'b1,
   parameter logic [7:0] TX_IDLE_BYTE = 8'hFF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i2c_scl_i,
   input  logic       i2c_sda_i,
   output logic       i2c_scl_oe,
   output logic       i2c_sda_oe,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   input  logic       rx_ready_i,
   input  logic [7:0] tx_data_i,
   input  logic       tx_valid_i,
   output logic       tx_ready_o,
   output logic       bus_start_o,
   output logic       bus_stop_o,
   output logic       addr_match_o,
   output logic       rw_o
);
   logic scl, scl_rise, scl_fall, sda, sda_rise, sda_fall;
   logic start, stop, tx_take;
   logic [7:0] byte_in;
   state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0] shift_q, shift_d, rx_data_q, rx_data_d;
   logic rx_valid_q, rx_valid_d, sda_oe_q, sda_oe_d, scl_oe_q, scl_oe_d;
   logic match_q, match_d, rw_q, rw_d, start_q, stop_q;

   i2c_input_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
      .clk(clk), .rst(rst), .d_i(i2c_scl_i), .q_o(scl), .rise_o(scl_rise), .fall_o(scl_fall)
   );
   i2c_input_sync #(.STAGES(SYNC_STAGES)) u_sda_sync (
      .clk(clk), .rst(rst), .d_i(i2c_sda_i), .q_o(sda), .rise_o(sda_rise), .fall_o(sda_fall)
   );

   assign start   = sda_fall & scl;
   assign stop    = sda_rise & scl;
   assign byte_in = {shift_q[6:0], sda};
   assign tx_take = (state_q == S_TX_LOAD) & tx_valid_i & ~start & ~stop;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      sda_oe_d   = sda_oe_q;
      scl_oe_d   = scl_oe_q;
      match_d    = match_q;
      rw_d       = rw_q;
      case (state_q)
         S_ADDR: if (scl_rise) begin
            shift_d = byte_in;
            cnt_d   = cnt_inc(cnt_q);
            if (cnt_q == CNT_W'(7)) begin
               cnt_d   = '0;
               match_d = byte_in[7:1] == I2C_ADDR;
               rw_d    = match_d & byte_in[0];
               state_d = match_d ? S_ADDR_ACK : S_IDLE;
            end
         end
         S_ADDR_ACK: if (scl_fall) begin
            sda_oe_d = ~sda_oe_q;
            if (sda_oe_q) state_d = rw_q ? S_TX_LOAD : S_RX_BYTE;
         end
         S_RX_BYTE: if (scl_rise) begin
            shift_d = byte_in;
            cnt_d   = cnt_inc(cnt_q);
            if (cnt_q == CNT_W'(7)) begin
               cnt_d      = '0;
               rx_data_d  = byte_in;
               rx_valid_d = 1'b1;
               state_d    = S_RX_ACK;
            end
         end
         S_RX_ACK: if (scl_fall) begin
            if (sda_oe_q) begin
               sda_oe_d = 1'b0;
               state_d  = S_RX_BYTE;
            end else if (rx_ready_i) sda_oe_d = 1'b1;
            else state_d = S_IDLE;
         end
         S_TX_LOAD: begin
            if (tx_valid_i) begin
               shift_d  = tx_data_i;
               sda_oe_d = ~tx_data_i[7];
               scl_oe_d = 1'b0;
               cnt_d    = CNT_W'(1);
               state_d  = S_TX_BYTE;
            end else if (STRETCH_EN) scl_oe_d = 1'b1;
            else begin
               shift_d  = TX_IDLE_BYTE;
               sda_oe_d = ~TX_IDLE_BYTE[7];
               cnt_d    = CNT_W'(1);
               state_d  = S_TX_BYTE;
            end
         end
         S_TX_BYTE: if (scl_fall) begin
            if (cnt_q == CNT_W'(8)) begin
               sda_oe_d = 1'b0;
               cnt_d    = '0;
               state_d  = S_TX_ACK;
            end else begin
               sda_oe_d = ~shift_q[6];
               shift_d  = {shift_q[6:0], 1'b0};
               cnt_d    = cnt_inc(cnt_q);
            end
         end
         S_TX_ACK: begin
            // cnt marks that the controller acknowledged on the 9th rise
            if (scl_rise) begin
               if (sda == ACK) cnt_d = CNT_W'(1);
               else state_d = S_IDLE;
            end else if (scl_fall && cnt_q != '0) begin
               cnt_d   = '0;
               state_d = S_TX_LOAD;
            end
         end
         default: ;
      endcase
      if (start) begin
         state_d  = S_ADDR;
         cnt_d    = '0;
         shift_d  = '0;
         sda_oe_d = 1'b0;
         scl_oe_d = 1'b0;
         match_d  = 1'b0;
         rw_d     = 1'b0;
      end else if (stop) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end
      if (state_d == S_IDLE) begin
         sda_oe_d = 1'b0;
         scl_oe_d = 1'b0;
         match_d  = 1'b0;
         rw_d     = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         shift_q    <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         sda_oe_q   <= 1'b0;
         scl_oe_q   <= 1'b0;
         match_q    <= 1'b0;
         rw_q       <= 1'b0;
         start_q    <= 1'b0;
         stop_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         sda_oe_q   <= sda_oe_d;
         scl_oe_q   <= scl_oe_d;
         match_q    <= match_d;
         rw_q       <= rw_d;
         start_q    <= start;
         stop_q     <= stop;
      end
   end

   // a bus condition seen during a stretch lets go of SCL without waiting for the register
   assign i2c_scl_oe   = scl_oe_q & ~start & ~stop;
   assign i2c_sda_oe   = sda_oe_q;
   assign rx_data_o    = rx_data_q;
   assign rx_valid_o   = rx_valid_q;
   assign tx_ready_o   = tx_take;
   assign bus_start_o  = start_q;
   assign bus_stop_o   = stop_q;
   assign addr_match_o = match_q;
   assign rw_o         = rw_q;
endmodule
